// File: rtl/alu_rr_arbiter_if.sv
// Client-side request/response bundle for the shared-ALU arbiter.
// master = issuing clients, slave = arbiter.
interface alu_rr_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_inA;
  logic [2*WIDTH-1:0] req_inB;
  logic [1:0]         req_inC;
  logic [5:0]         req_opc;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_zer;
  logic               rsp_neg;

  modport master (
    output req_valid, req_inA, req_inB,
    output req_inC, req_opc, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_zer, rsp_neg
  );

  modport slave (
    input  req_valid, req_inA, req_inB,
    input  req_inC, req_opc, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_data, rsp_zer, rsp_neg
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-client round-robin sequencer in front of one combinational ALU.
// One op in flight: accept -> exec -> respond.
module alu_rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_rr_arbiter_if.slave  cl,
  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic             alu_inC,
  output logic [2:0]       alu_opc,
  input  logic [WIDTH-1:0] alu_outW,
  input  logic             alu_zer,
  input  logic             alu_neg,
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic             ptr_q;
  logic             owner_q;
  logic             busy_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic             opC_q;
  logic [2:0]       opc_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zer_q;
  logic             rsp_neg_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic             win;
  logic             accept;
  logic             done;
  logic [WIDTH-1:0] opA_d;
  logic [WIDTH-1:0] opB_d;
  logic             opC_d;
  logic [2:0]       opc_d;

  // Preferred requester wins if valid, else the other one.
  assign win    = cl.req_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign accept = (state_q == IDLE) & (|cl.req_valid) & ~rst;
  assign done   = (state_q == RESP) & cl.rsp_ready[owner_q];

  assign opA_d = win ? cl.req_inA[2*WIDTH-1:WIDTH]
                     : cl.req_inA[WIDTH-1:0];
  assign opB_d = win ? cl.req_inB[2*WIDTH-1:WIDTH]
                     : cl.req_inB[WIDTH-1:0];
  assign opC_d = cl.req_inC[win];
  assign opc_d = win ? cl.req_opc[5:3] : cl.req_opc[2:0];

  assign cl.req_ready = {accept & win, accept & ~win};
  assign cl.rsp_valid = rsp_valid_q;
  assign cl.rsp_data  = rsp_data_q;
  assign cl.rsp_zer   = rsp_zer_q;
  assign cl.rsp_neg   = rsp_neg_q;

  assign alu_inA    = opA_q;
  assign alu_inB    = opB_q;
  assign alu_inC    = opC_q;
  assign alu_opc    = opc_q;
  assign busy       = busy_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      opA_q       <= '0;
      opB_q       <= '0;
      opC_q       <= 1'b0;
      opc_q       <= 3'd0;
      rsp_data_q  <= '0;
      rsp_zer_q   <= 1'b0;
      rsp_neg_q   <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            opC_q   <= opC_d;
            opc_q   <= opc_d;
            owner_q <= win;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_outW;
          rsp_zer_q   <= alu_zer;
          rsp_neg_q   <= alu_neg;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (done) begin
            if (owner_q) cnt1_q <= cnt1_q + CNT_W'(1);
            else         cnt0_q <= cnt0_q + CNT_W'(1);
            ptr_q       <= ~owner_q;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Randomized + directed bench for alu_rr_arbiter.
// Owns the ALU model and a transaction-level reference model.
module tb_alu_rr_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_rr_arbiter_if #(.WIDTH(W)) ifc ();

  logic [W-1:0] alu_inA;
  logic [W-1:0] alu_inB;
  logic         alu_inC;
  logic [2:0]   alu_opc;
  logic [W-1:0] alu_outW;
  logic         alu_zer;
  logic         alu_neg;
  logic         busy;
  logic [7:0]   gc0;
  logic [7:0]   gc1;

  alu_rr_arbiter #(.WIDTH(W), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cl        (ifc.slave),
    .alu_inA   (alu_inA),
    .alu_inB   (alu_inB),
    .alu_inC   (alu_inC),
    .alu_opc   (alu_opc),
    .alu_outW  (alu_outW),
    .alu_zer   (alu_zer),
    .alu_neg   (alu_neg),
    .busy      (busy),
    .grant_cnt0(gc0),
    .grant_cnt1(gc1)
  );

  logic [1:0]   v;
  logic [1:0]   rr;
  logic [1:0]   acc;
  logic         hold;
  logic [W-1:0] pa [2];
  logic [W-1:0] pb [2];
  logic         pc [2];
  logic [2:0]   po [2];

  assign ifc.req_valid = v;
  assign ifc.req_inA   = {pa[1], pa[0]};
  assign ifc.req_inB   = {pb[1], pb[0]};
  assign ifc.req_inC   = {pc[1], pc[0]};
  assign ifc.req_opc   = {po[1], po[0]};
  assign ifc.rsp_ready = rr;

  function automatic logic [W-1:0] alu_f(
    input logic [2:0] o, input logic [W-1:0] a,
    input logic [W-1:0] b, input logic c);
    case (o)
      3'd0:    return b - a;
      3'd1:    return a & b;
      3'd2:    return a + b + W'(c);
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return {a[7:0], b[7:0]};
      default: return '0;
    endcase
  endfunction

  assign alu_outW = alu_f(alu_opc, alu_inA, alu_inB, alu_inC);
  assign alu_zer  = (alu_outW == '0);
  assign alu_neg  = alu_outW[W-1];

  // Reference model: one op outstanding, aged in cycles since accept.
  logic         m_busy;
  logic         m_ptr;
  logic         m_own;
  int           m_age;
  logic [W-1:0] m_a, m_b, m_res;
  logic         m_c;
  logic [2:0]   m_o;
  logic [7:0]   m_cnt [2];
  int           cyc;
  int           ndone;
  int           g_own [$];
  int           g_cyc [$];
  logic [W-1:0] o_data [$];
  logic         o_zer [$];
  logic         o_neg [$];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  task automatic m_reset();
    m_busy = 1'b0;
    m_ptr = 1'b0;
    m_own = 1'b0;
    m_age = 0;
    m_cnt[0] = 8'd0;
    m_cnt[1] = 8'd0;
  endtask

  task automatic clear_log();
    g_own.delete();
    g_cyc.delete();
    o_data.delete();
    o_zer.delete();
    o_neg.delete();
    ndone = 0;
  endtask

  task automatic cycle();
    logic w;
    logic [1:0] er, ev;
    @(negedge clk);
    w  = v[m_ptr] ? m_ptr : ~m_ptr;
    er = (!rst && !m_busy && (v != 2'b00)) ? oh(w) : 2'b00;
    ev = (m_busy && m_age >= 2) ? oh(m_own) : 2'b00;
    chk("req_ready", 32'(ifc.req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rsp_valid", 32'(ifc.rsp_valid), 32'(ev));
    if (m_busy && m_age >= 2) begin
      chk("rsp_data", 32'(ifc.rsp_data), 32'(m_res));
      chk("rsp_zer", 32'(ifc.rsp_zer), 32'(m_res == '0));
      chk("rsp_neg", 32'(ifc.rsp_neg), 32'(m_res[W-1]));
    end
    if (m_busy && m_age == 1) begin
      chk("alu_opc", 32'(alu_opc), 32'(m_o));
      chk("alu_inA", 32'(alu_inA), 32'(m_a));
      chk("alu_inB", 32'(alu_inB), 32'(m_b));
      chk("alu_inC", 32'(alu_inC), 32'(m_c));
    end
    chk("cnt0", 32'(gc0), 32'(m_cnt[0]));
    chk("cnt1", 32'(gc1), 32'(m_cnt[1]));
    acc = 2'b00;
    if (rst) begin
      m_reset();
    end else if (!m_busy) begin
      if (v != 2'b00) begin
        m_busy = 1'b1;
        m_age = 1;
        m_own = w;
        m_a = pa[w];
        m_b = pb[w];
        m_c = pc[w];
        m_o = po[w];
        m_res = alu_f(m_o, m_a, m_b, m_c);
        acc[w] = 1'b1;
        g_own.push_back(int'(w));
        g_cyc.push_back(cyc);
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (rr[m_own]) begin
      o_data.push_back(ifc.rsp_data);
      o_zer.push_back(ifc.rsp_zer);
      o_neg.push_back(ifc.rsp_neg);
      m_cnt[m_own] = m_cnt[m_own] + 8'd1;
      m_ptr = ~m_own;
      m_busy = 1'b0;
      ndone++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!hold) v = v & ~acc;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || v != 2'b00) && n < 60) begin
      cycle();
      n++;
    end
    chk("drain", 32'(m_busy || v != 2'b00), 32'd0);
  endtask

  initial begin
    v = 2'b00;
    rr = 2'b00;
    hold = 1'b0;
    acc = 2'b00;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      pa[i] = '0;
      pb[i] = '0;
      pc[i] = 1'b0;
      po[i] = 3'd0;
    end
    m_reset();
    clear_log();
    repeat (3) @(posedge clk);
    #1;

    // reset holds req_ready low even with both valid
    v = 2'b11;
    do_rst();
    chk("rst_data", 32'(ifc.rsp_data), 32'd0);
    chk("rst_opc", 32'(alu_opc), 32'd0);
    v = 2'b00;

    // single op, response stalled 5 cycles with req1 waiting
    clear_log();
    pa[0] = 16'h0003; pb[0] = 16'h0004; pc[0] = 1'b1; po[0] = 3'd2;
    v = 2'b01;
    rr = 2'b00;
    repeat (3) cycle();
    pa[1] = 16'h00F0; pb[1] = 16'h0F0F; pc[1] = 1'b0; po[1] = 3'd1;
    v = 2'b10;
    repeat (5) cycle();
    rr = 2'b01;
    cycle();
    chk("t1_n", 32'(o_data.size()), 32'd1);
    chk("t1_data", 32'(o_data[0]), 32'h0008);
    chk("t1_zer", 32'(o_zer[0]), 32'd0);
    chk("t1_neg", 32'(o_neg[0]), 32'd0);
    chk("t1_cnt0", 32'(gc0), 32'd1);
    rr = 2'b11;
    drain();
    chk("t1_own1", 32'(g_own[1]), 32'd1);

    // both valid right after reset
    do_rst();
    clear_log();
    pa[0] = 16'h0001; pb[0] = 16'h0000; pc[0] = 1'b0; po[0] = 3'd0;
    pa[1] = 16'h5A5A; pb[1] = 16'h1234; pc[1] = 1'b1; po[1] = 3'd7;
    v = 2'b11;
    rr = 2'b11;
    drain();
    chk("t2_own0", 32'(g_own[0]), 32'd0);
    chk("t2_own1", 32'(g_own[1]), 32'd1);
    chk("t2_d0", 32'(o_data[0]), 32'hFFFF);
    chk("t2_n0", 32'(o_neg[0]), 32'd1);
    chk("t2_d1", 32'(o_data[1]), 32'h0000);
    chk("t2_z1", 32'(o_zer[1]), 32'd1);

    // continuous contention
    do_rst();
    clear_log();
    hold = 1'b1;
    v = 2'b11;
    for (int n = 0; n < 40 && g_own.size() < 4; n++) cycle();
    hold = 1'b0;
    v = 2'b00;
    drain();
    chk("t3_grants", 32'(g_own.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t3_order", 32'(g_own[i]), 32'(i % 2));
    for (int i = 0; i < 3; i++)
      chk("t3_space", 32'(g_cyc[i+1] - g_cyc[i]), 32'd3);
    chk("t3_cnt0", 32'(gc0), 32'd2);
    chk("t3_cnt1", 32'(gc1), 32'd2);

    // only req1 valid while ptr=0
    do_rst();
    clear_log();
    pa[1] = 16'h12AB; pb[1] = 16'h34CD; pc[1] = 1'b0; po[1] = 3'd6;
    v = 2'b10;
    drain();
    chk("t4_own", 32'(g_own[0]), 32'd1);
    chk("t4_data", 32'(o_data[0]), 32'hABCD);
    chk("t4_neg", 32'(o_neg[0]), 32'd1);

    // reset during EXEC discards the op
    do_rst();
    clear_log();
    v = 2'b01;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rv", 32'(ifc.rsp_valid), 32'd0);
    chk("t6_cnt0", 32'(gc0), 32'd0);
    v = 2'b11;
    drain();
    chk("t6_rsps", 32'(o_data.size()), 32'd2);
    chk("t6_own", 32'(g_own[1]), 32'd0);

    // grant_cnt0 wrap
    do_rst();
    clear_log();
    hold = 1'b1;
    v = 2'b01;
    rr = 2'b01;
    for (int n = 0; n < 1200 && ndone < 256; n++) cycle();
    hold = 1'b0;
    v = 2'b00;
    drain();
    chk("t7_n", 32'(ndone), 32'd256);
    chk("t7_wrap", 32'(gc0), 32'd0);

    // random traffic with occasional reset
    do_rst();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          pa[i] = W'($urandom);
          pb[i] = W'($urandom);
          pc[i] = 1'($urandom);
          po[i] = 3'($urandom);
        end
      end
      rr = 2'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
      rst = 1'b0;
    end
    rr = 2'b11;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Two-requester round-robin arbiter and sequencer that shares one 16-bit ALU (8 opcodes, result plus zer/neg flags) between two clients. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and opcode ports from registers. It captures the ALU result, flags and requester ID, and returns them on a response handshake. It sits between the two issuing clients and the single ALU instance.

Parameters:
WIDTH, 16, operand/result width; must match the ALU datapath
CNT_W, 8, width of the per-requester grant counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  2  per-requester request valid; bit i = requester i
req_ready  output  2  per-requester accept; at most one bit high
req_inA  input  2*WIDTH  operand A; slice [i*WIDTH +: WIDTH] belongs to requester i
req_inB  input  2*WIDTH  operand B; same slicing
req_inC  input  2  carry-in per requester
req_opc  input  6  opcode per requester; slice [i*3 +: 3]
alu_inA  output  WIDTH  to ALU inA
alu_inB  output  WIDTH  to ALU inB
alu_inC  output  1  to ALU inC
alu_opc  output  3  to ALU opc
alu_outW  input  WIDTH  from ALU result
alu_zer  input  1  from ALU zero flag
alu_neg  input  1  from ALU negative flag
rsp_valid  output  2  response valid for requester i; one-hot or zero
rsp_ready  input  2  per-requester response accept
rsp_data  output  WIDTH  captured result
rsp_zer  output  1  captured zero flag
rsp_neg  output  1  captured negative flag
busy  output  1  high in any state other than IDLE
grant_cnt0  output  CNT_W  operations completed for requester 0, wraps
grant_cnt1  output  CNT_W  operations completed for requester 1, wraps

Behaviour:
- The ALU is purely combinational. alu_* outputs come only from the operand registers opA_q, opB_q, opC_q and opc_q, never from req_* directly.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, select the winner w by round-robin. Pointer ptr names the preferred requester. If req_valid[ptr] is set, w = ptr; otherwise w = the other requester (work-conserving).
  - req_ready[w] is high combinationally in that same cycle and the transfer completes.
  - On that edge: latch the operands and opcode of w into the op registers, latch owner_q = w, go to EXEC.
  - If no request is valid, req_ready = 0 and the FSM stays in IDLE.
- EXEC: on this edge capture alu_outW, alu_zer and alu_neg into rsp_data, rsp_zer and rsp_neg, then go to RESP. req_ready = 0.
- RESP:
  - rsp_valid[owner_q] = 1. rsp_data and the flags hold stable. req_ready = 0.
  - When rsp_ready[owner_q] is high: increment grant_cnt of owner_q (wraps to 0 from all-ones), set ptr = ~owner_q, go to IDLE.
  - rsp_ready[~owner_q] is ignored.
- Latency: accept at edge N, rsp_valid visible after edge N+2. Minimum 3 cycles per operation; back-to-back acceptance occurs at most every 3rd cycle.
- Opcodes are passed through unmodified. Opcode 111 is legal and yields rsp_data 0 with rsp_zer 1. There is no illegal-opcode detection.
- Simultaneous valid on both requesters: exactly one is granted, per ptr. The loser's request must stay pending; clients must hold valid and payload until ready.
- Under continuous contention, grants strictly alternate 0,1,0,1.
- Reset, in any state including EXEC and RESP, takes effect on the next clk edge:
  - state = IDLE, ptr = 0, all op registers and rsp_data = 0, rsp_zer = rsp_neg = 0.
  - rsp_valid = 0, req_ready = 0, busy = 0, both grant counters = 0.
  - An in-flight operation is discarded with no response.
- While rst is high, req_ready = 0 regardless of req_valid.

Test Plan:
- Requester 0 only, opc=010, A=0x0003, B=0x0004, C=1 -> req_ready[0] high in accept cycle; rsp_valid=2'b01 two cycles later; rsp_data=0x0008, zer=0, neg=0; grant_cnt0=1 after rsp_ready.
- Both valid right after reset: req0 opc=000, A=0x0001; req1 opc=111 -> req0 served first with rsp_data=0xFFFF, neg=1; then req1 with rsp_data=0x0000, zer=1; rsp_valid sequence 01 then 10.
- Both valid continuously for 4 operations, rsp_ready tied high -> grant order 0,1,0,1; accepts spaced exactly 3 cycles; grant_cnt0=grant_cnt1=2.
- Only req1 valid while ptr=0, opc=110, A=0x12AB, B=0x34CD -> req1 granted immediately; rsp_data=0xABCD, neg=1.
- In RESP, hold rsp_ready low 5 cycles -> rsp_valid and rsp_data stable; req_ready=2'b00 throughout; busy=1; no new accept.
- rst pulsed high one cycle while in EXEC -> next cycle: busy=0, rsp_valid=0, counters 0; the following request with ptr=0 and both valid grants requester 0.
- Counter wrap: 256 requester-0 operations -> grant_cnt0 returns to 0x00.
